bitop_rr_arbiter: RTL
=====================

Name: bitop_rr_arbiter

Overview:
- Shares one 16-bit bitwise logic unit (AND/OR/XOR/NAND) among NUM_REQ requesters using round-robin arbitration.
- Each requester uses a valid/ready request channel. One registered response channel returns the result tagged with the requester index.
- Sits between ALU-side helper logic and the shared bitwise datapath. It is the single sequencing point for that resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand and result width.
- ID_W, 2, width of the requester index; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*WIDTH  flattened operand A; requester i uses [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  flattened operand B, same packing.
- req_op  in  NUM_REQ*2  flattened opcode, 2 bits per requester.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_data  out  WIDTH  result.
- rsp_id  out  ID_W  index of the requester that produced rsp_data.

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset, rst_n.
- Opcodes: 00 AND, 01 OR, 10 XOR, 11 NAND. The result is computed combinationally from the granted operands and registered on acceptance.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0 (requester 0 has highest priority), state=IDLE.
- States:
  - IDLE: no held result.
  - HOLD: rsp_valid=1 and the result is held stable.
- can_accept = (state==IDLE) || rsp_ready.
- Grant selection: the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
- req_ready[i] = can_accept && (i == grant index) && req_valid[i]. req_ready is 0 for all requesters when none is valid.
- Accept (any req_ready bit high):
  - Next cycle: rsp_valid=1, rsp_data=op result, rsp_id=grant index, state=HOLD.
  - rr_ptr = (grant index + 1) mod NUM_REQ.
- HOLD with rsp_ready=1 and no accept: state=IDLE, rsp_valid=0. rsp_data and rsp_id keep their last values.
- HOLD with rsp_ready=1 and a same-cycle accept: back-to-back operation; stay in HOLD with the new result. Throughput is 1 op/cycle.
- HOLD with rsp_ready=0: rsp_data and rsp_id stay stable; no req_ready asserted.
- Latency: 1 cycle from accept to rsp_valid.
- Requester rules:
  - Must hold req_a, req_b and req_op stable while req_valid=1 and not accepted.
  - May drop req_valid without penalty.
  - A dropped request does not move rr_ptr.
- Reset mid-operation: the held result is discarded, rsp_valid goes to 0 immediately (asynchronous), and rr_ptr returns to 0.
- rr_ptr only advances on accept, never on idle cycles.
- Unused ID codes (NUM_REQ not a power of two) never appear on rsp_id.

Optional Feature:
- Macro: BITOP_ARB_STATS_EN.
- With the macro:
  - Adds output grant_count of width NUM_REQ*16: one saturating 16-bit counter per requester.
  - Counter i increments on each accept of requester i and holds at 16'hFFFF.
  - All counters reset to 0 asynchronously.
  - Adds input stats_clr (1 bit); it synchronously zeroes all counters and takes priority over a same-cycle increment.
- Without the macro: neither port exists and no counter logic is built. Arbitration behaviour is identical.

Decomposition:
- Package bitop_pkg:
  - OP_AND, OP_OR, OP_XOR, OP_NAND 2-bit constants.
  - bitop_op_t typedef.
  - Default WIDTH constant.
- Sub-module bitop_unit: purely combinational a/b/op -> out, built from the team's And16-style 16-bit gate blocks. The arbiter instantiates it once after the grant multiplexer.

Test Plan:
- Single request: after reset, req_valid=4'b0001, a=16'hF0F0, b=16'h0FF0, op=AND → req_ready[0] same cycle; next cycle rsp_valid=1, rsp_data=16'h00F0, rsp_id=0.
- Round-robin: all four valid continuously, rsp_ready=1 → grants 0,1,2,3,0 on consecutive cycles; one result per cycle, rsp_id following that sequence.
- Backpressure: rsp_ready=0 after a NAND of 16'hFFFF and 16'h00FF → rsp_data=16'hFF00 held 5 cycles; no req_ready during the stall. Raising rsp_ready accepts the next requester in the same cycle.
- Wrap and skip: last grant=2, then only req_valid[1]=1 → requester 1 granted (wrap via 3,0); rr_ptr=2 afterwards.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 → rsp_valid=0 without a clock edge. After release, requester 0 wins over 3 when both are valid.
- Stats (BITOP_ARB_STATS_EN): 3 accepts for requester 1 → grant_count[31:16]=3. Pulse stats_clr on a cycle with an accept → all counters read 0.

Source files
------------

// File: rtl/bitop_pkg.sv
// Shared constants and types for the round-robin bitwise-logic arbiter.
package bitop_pkg;

    localparam int BITOP_WIDTH = 16;

    typedef logic [1:0] bitop_op_t;

    localparam bitop_op_t OP_AND  = 2'b00;
    localparam bitop_op_t OP_OR   = 2'b01;
    localparam bitop_op_t OP_XOR  = 2'b10;
    localparam bitop_op_t OP_NAND = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bitop_unit.sv
// Purely combinational bitwise logic unit: per-bit gate slices feeding an opcode mux.
module bitop_unit
    import bitop_pkg::*;
#(
    parameter int WIDTH = BITOP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  bitop_op_t        op,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] xor_bits;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gate
            assign and_bits[gi] = a[gi] & b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
            assign xor_bits[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    // NAND reuses the AND slice rather than building a separate gate row.
    always_comb begin
        y = and_bits;
        case (op)
            OP_AND:  y = and_bits;
            OP_OR:   y = or_bits;
            OP_XOR:  y = xor_bits;
            OP_NAND: y = ~and_bits;
            default: y = and_bits;
        endcase
    end

endmodule

// File: rtl/bitop_rr_arbiter.sv
// Round-robin arbiter sharing one bitop_unit among NUM_REQ requesters, 1-deep response register.
// Optional per-requester saturating grant counters when BITOP_ARB_STATS_EN is defined.
module bitop_rr_arbiter
    import bitop_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = BITOP_WIDTH,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]     req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id
`ifdef BITOP_ARB_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [NUM_REQ*16-1:0]    grant_count
`endif
);

    arb_state_t       state_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic [ID_W-1:0]  rr_ptr_reg;

    logic [WIDTH-1:0] a_arr  [NUM_REQ];
    logic [WIDTH-1:0] b_arr  [NUM_REQ];
    bitop_op_t        op_arr [NUM_REQ];

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    bitop_op_t        grant_op;
    logic [WIDTH-1:0] unit_y;

    function automatic int wrap_idx(input int base, input int offset);
        int sum;
        sum = base + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
            assign op_arr[gi] = bitop_op_t'(req_op[gi*2 +: 2]);
        end
    endgenerate

    // Search upward from rr_ptr, wrapping; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_idx(int'(rr_ptr_reg), k)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(wrap_idx(int'(rr_ptr_reg), k));
            end
        end
    end

    assign can_accept = (state_reg == ST_IDLE) || rsp_ready;
    assign accept     = can_accept && grant_found;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign grant_a  = a_arr[grant_idx];
    assign grant_b  = b_arr[grant_idx];
    assign grant_op = op_arr[grant_idx];

    bitop_unit #(
        .WIDTH(WIDTH)
    ) u_unit (
        .a  (grant_a),
        .b  (grant_b),
        .op (grant_op),
        .y  (unit_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
            rr_ptr_reg    <= '0;
        end else if (accept) begin
            state_reg     <= ST_HOLD;
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= unit_y;
            rsp_id_reg    <= grant_idx;
            rr_ptr_reg    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end else if ((state_reg == ST_HOLD) && rsp_ready) begin
            // Result drained with nothing new: data/id deliberately keep their last values.
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;

`ifdef BITOP_ARB_STATS_EN
    logic [15:0] count_reg [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg[gi] <= '0;
                end else if (stats_clr) begin
                    count_reg[gi] <= '0;
                end else if (req_ready[gi] && (count_reg[gi] != 16'hFFFF)) begin
                    count_reg[gi] <= count_reg[gi] + 16'd1;
                end
            end
            assign grant_count[gi*16 +: 16] = count_reg[gi];
        end
    endgenerate
`endif

endmodule
